// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path.
// Holds the receiver FSM states, default framing parameters and the bus register map.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int DATA_BITS  = 8;

    // Register map; prefixed because DATA is already taken by the FSM state.
    localparam logic [1:0] IOADDR_DATA    = 2'b00;
    localparam logic [1:0] IOADDR_STATUS  = 2'b01;
    localparam logic [1:0] IOADDR_DB_LOW  = 2'b10;
    localparam logic [1:0] IOADDR_DB_HIGH = 2'b11;

endpackage

// File: rtl/rx_unit_if.sv
// Receiver-to-bus interface: received byte, status flags and the read acknowledge.
interface rx_unit_if #(
    parameter int DATA_BITS = spart_pkg::DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun;
    logic                 clr_rda;

    modport slave  (output rx_data, rda, framing_err, overrun, input  clr_rda);
    modport master (input  rx_data, rda, framing_err, overrun, output clr_rda);
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/rx_unit.sv
// Oversampling UART receiver: start-bit validation at mid-bit, LSB-first payload, stop check.
// Optional overrun flag is built only when RX_OVERRUN_EN is defined.
module rx_unit #(
    parameter int OVERSAMPLE = spart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = spart_pkg::DATA_BITS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rxd,
    input  logic     rx_en,
    rx_unit_if.slave bus
);
    import spart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 ferr_q, ferr_d;
    logic                 rxd_prev_q, rxd_prev_d;
    logic                 rxd_s;
    logic                 load;
    logic                 stop_err;

    rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rxd_prev_d = rxd_s;
        load       = 1'b0;
        stop_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxd_prev_q && !rxd_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (rx_en) begin
                    if (tick_q == HALF_TICK) begin
                        tick_d    = '0;
                        bit_cnt_d = '0;
                        state_d   = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (rx_en) begin
                    tick_d = (tick_q == LAST_TICK) ? '0 : tick_q + TW'(1);
                    if (tick_q == LAST_TICK) begin
                        shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (rx_en) begin
                    tick_d = (tick_q == LAST_TICK) ? '0 : tick_q + TW'(1);
                    if (tick_q == LAST_TICK) begin
                        load     = rxd_s;
                        stop_err = !rxd_s;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A byte load in the same cycle as an acknowledge leaves rda set for the new byte.
    always_comb begin
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        ferr_d    = ferr_q;
        if (bus.clr_rda) begin
            rda_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (load) begin
            rx_data_d = shift_q;
            rda_d     = 1'b1;
            ferr_d    = 1'b0;
        end
        if (stop_err) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rda_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rda_q      <= rda_d;
            ferr_q     <= ferr_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rda         = rda_q;
    assign bus.framing_err = ferr_q;

`ifdef RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (bus.clr_rda) begin
            overrun_d = 1'b0;
        end else if (load && rda_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rx_unit.sv
// Scoreboard bench for rx_unit: directed frames push expected output snapshots,
// a negedge monitor pops one on every change of the receiver outputs.
module tb_rx_unit;

`ifdef RX_OVERRUN_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    typedef struct {
        logic [10:0] v;
        int          en_at;
    } exp_t;

    logic clk;
    logic rst;
    logic rxd;
    logic rx_en;

    int   asserts;
    int   failures;
    int   en_count;
    bit   mon_en;
    exp_t exp_q[$];
    logic [10:0] prev_v;

    rx_unit_if bus ();

    rx_unit dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rx_en (rx_en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: timeout reached, queue=%0d", exp_q.size());
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [10:0] pack(input logic [7:0] d, input logic r,
                                         input logic f, input logic o);
        return {d, r, f, o};
    endfunction

    task automatic expect_out(input logic [7:0] d, input logic r, input logic f,
                              input logic o, input int en_at);
        exp_t e;
        e.v     = pack(d, r, f, o);
        e.en_at = en_at;
        exp_q.push_back(e);
    endtask

    // Any change on the outputs must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [10:0] cur;
        exp_t        e;
        cur = {bus.rx_data, bus.rda, bus.framing_err, bus.overrun};
        if (mon_en && (cur !== prev_v)) begin
            asserts++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_change: got %h, nothing expected", cur);
            end else begin
                e = exp_q.pop_front();
                if ((cur !== e.v) || ((e.en_at >= 0) && (en_count != e.en_at))) begin
                    failures++;
                    $display("[TB] FAIL scoreboard: got %h at rx_en %0d, expected %h at rx_en %0d",
                             cur, en_count, e.v, e.en_at);
                end
            end
            prev_v = cur;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] d, input logic r,
                               input logic f, input logic o);
        logic [10:0] cur;
        cur = {bus.rx_data, bus.rda, bus.framing_err, bus.overrun};
        asserts++;
        if (cur !== pack(d, r, f, o)) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, cur, pack(d, r, f, o));
        end
    endtask

    task automatic pulseEn(input logic clr);
        rx_en       = 1'b1;
        bus.clr_rda = clr;
        en_count++;
        @(negedge clk);
        rx_en       = 1'b0;
        bus.clr_rda = 1'b0;
        @(negedge clk);
    endtask

    task automatic clrPulse(input logic [7:0] d);
        expect_out(d, 1'b0, 1'b0, 1'b0, -1);
        bus.clr_rda = 1'b1;
        @(negedge clk);
        bus.clr_rda = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Sends start, payload LSB first, then stop; abort_at > 0 returns after that many ticks.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input bit clr_at_stop, input int abort_at);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        rxd  = 1'b0;
        repeat (3) @(negedge clk);
        en_count = 0;
        for (int b = 0; b < 10; b++) begin
            rxd = bits[b];
            for (int t = 0; t < 16; t++) begin
                if ((abort_at > 0) && (en_count == abort_at)) return;
                pulseEn(clr_at_stop && (en_count == 151));
            end
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        asserts     = 0;
        failures    = 0;
        en_count    = 0;
        mon_en      = 1'b0;
        prev_v      = '0;
        rst         = 1'b0;
        rxd         = 1'b1;
        rx_en       = 1'b0;
        bus.clr_rda = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        repeat (200) pulseEn(1'b0);
        checkOutput("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        expect_out(8'hEF, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'hEF, 1'b1, 1'b0, 0);
        checkOutput("frame_ef", 8'hEF, 1'b1, 1'b0, 1'b0);
        clrPulse(8'hEF);

        expect_out(8'hEF, 1'b0, 1'b1, 1'b0, 152);
        applyStimulus(8'h84, 1'b0, 1'b0, 0);
        checkOutput("framing_err", 8'hEF, 1'b0, 1'b1, 1'b0);
        clrPulse(8'hEF);
        checkOutput("framing_clr", 8'hEF, 1'b0, 1'b0, 1'b0);

        rxd = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) pulseEn(1'b0);
        rxd = 1'b1;
        repeat (12) pulseEn(1'b0);
        checkOutput("glitch", 8'hEF, 1'b0, 1'b0, 1'b0);

        expect_out(8'h84, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'h84, 1'b1, 1'b0, 0);
        checkOutput("after_glitch", 8'h84, 1'b1, 1'b0, 1'b0);

        expect_out(8'h55, 1'b1, 1'b0, OV_EN, 152);
        applyStimulus(8'h55, 1'b1, 1'b0, 0);
        checkOutput("overrun", 8'h55, 1'b1, 1'b0, OV_EN);
        clrPulse(8'h55);

        expect_out(8'h84, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'h84, 1'b1, 1'b0, 0);
        expect_out(8'h55, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'h55, 1'b1, 1'b1, 0);
        checkOutput("clr_with_load", 8'h55, 1'b1, 1'b0, 1'b0);

        applyStimulus(8'hA5, 1'b1, 1'b0, 84);
        expect_out(8'h00, 1'b0, 1'b0, 1'b0, -1);
        #1 rst = 1'b0;
        #1 checkOutput("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) pulseEn(1'b0);

        expect_out(8'hA5, 1'b1, 1'b0, 1'b0, 152);
        applyStimulus(8'hA5, 1'b1, 1'b0, 0);
        checkOutput("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0);

        for (int i = 0; (i < 20) && (exp_q.size() != 0); i++) @(negedge clk);
        asserts++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/rx_unit.md
RX_UNIT -- requirements
Module: rx_unit

Interface
REQ-001: Parameter OVERSAMPLE, default 16, means rx_en ticks per bit.
REQ-002: Parameter DATA_BITS, default 8, means payload bits per frame, sent LSB first.
REQ-003: clk  input  1  system clock; all flops on posedge.
REQ-004: rst  input  1  reset, asynchronous, active-low.
REQ-005: rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-006: rx_en  input  1  one-clk oversample enable pulse from baud_gen, OVERSAMPLE per bit.
REQ-007: clr_rda  input  1  one-clk acknowledge from the bus interface on a DATA read.
REQ-008: rx_data  output  DATA_BITS  last received byte.
REQ-009: rda  output  1  receive data available.
REQ-010: framing_err  output  1  stop bit sampled low.
REQ-011: overrun  output  1  a byte completed while rda was already 1.

Function
REQ-012: rxd passes through a 2-flop synchronizer (flop reset value 1); all decisions use the synchronized value rxd_s.
REQ-013: The FSM states are IDLE, START, DATA, STOP.
REQ-014: IDLE -> START occurs on a falling edge of rxd_s (previous 1, current 0), and clears the tick counter; a held-low line does not retrigger.
REQ-015: In START, the tick counter advances only on rx_en; at tick OVERSAMPLE/2-1 (7), rxd_s=1 means false start -> IDLE, and rxd_s=0 -> DATA with the tick counter and bit counter cleared.
REQ-016: In DATA, rxd_s is sampled when the tick counter reaches OVERSAMPLE-1 (15) on an rx_en, shifted into bit[DATA_BITS-1] with a right shift, and the bit counter increments; the FSM goes -> STOP after the DATA_BITS-th sample.
REQ-017: In STOP, sampling occurs at tick 15; stop=1 loads rx_data, sets rda, clears framing_err; stop=0 sets framing_err, leaves rx_data and rda unchanged; both cases -> IDLE.
REQ-018: rda/rx_data update on the clk edge of the sampling rx_en; no extra latency.
REQ-019: clr_rda clears rda, framing_err and overrun the next edge.
REQ-020: A byte load with rda=1 and clr_rda=0 overwrites rx_data and sets overrun.
REQ-021: A simultaneous byte load and clr_rda overwrites rx_data, keeps rda=1 and does not set overrun.
REQ-022: With rx_en low, no counter or state changes occur; the tick counter wraps 15->0 in DATA/STOP.
REQ-023: clr_rda has no effect on the FSM or counters.

Reset
REQ-024: While rst=0, the state is IDLE, counters and shift register are 0, synchronizer flops are 1, rx_data=0, and rda, framing_err and overrun are 0.
REQ-025: Reset asserted mid-frame abandons the frame with no partial load; reception resumes on the next falling edge after release.

Configuration
REQ-026: The macro is RX_OVERRUN_EN; when defined, overrun behaves per REQ-020/021.
REQ-027: Without RX_OVERRUN_EN, the overrun port remains, is tied to 0, and no overrun flop exists.

Structure
REQ-028: Package spart_pkg holds the rx_state_t enum (IDLE, START, DATA, STOP), OVERSAMPLE, MID_TICK=7, DATA_BITS, and the ioaddr constants DATA/STATUS/DB_LOW/DB_HIGH.
REQ-029: A single sub-module, rx_sync (2-flop synchronizer, reset-to-1), is instantiated for rxd.

Verification
REQ-030: Idle: rxd=1 for 200 rx_en ticks -> rda=0, rx_data=8'h00, and the state stays IDLE.
REQ-031: Frame 8'hEF (stop=1, 16 ticks/bit) -> rx_data=8'hEF, rda=1 on the 152nd rx_en after the start edge (+2 clk synchronizer), framing_err=0.
REQ-032: Glitch: rxd low for 4 ticks then high -> START aborts to IDLE at tick 7, rda=0, and the following 8'h84 frame is received correctly.
REQ-033: Frame 8'h84 with stop=0 -> framing_err=1, rda=0, rx_data unchanged; a clr_rda pulse -> framing_err=0.
REQ-034: Frames 8'h84 then 8'h55 with no clr_rda -> rx_data=8'h55, rda=1, overrun=1 (0 if RX_OVERRUN_EN is undefined); clr_rda coincident with the second load -> overrun=0.
REQ-035: rst=0 during data bit 4 -> all outputs 0 immediately; after release, frame 8'hA5 -> rx_data=8'hA5, rda=1.
